// File: rtl/ps2_key_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_rx
// Brief    : PS/2 keyboard receiver producing the 11-bit {toggle, pressed,
//            extended, code} key event word with strobe and frame-error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 24000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int c_FILT_W = (FILTER  < 1) ? 1 : $clog2(FILTER + 1);
    localparam int c_TMO_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILTER - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LIM   = c_TMO_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]         w_raw;
    logic [1:0]         w_filt;
    logic               w_data;
    logic               r_clk_prev;
    logic               w_fall;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_par;
    logic               w_par_ok;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_tmo;
    logic               w_byte_ok;
    logic               w_frame_bad;

    logic               r_ext;
    logic               r_rel;
    logic [2:0]         r_skip;
    logic [10:0]        r_key;
    logic               r_strobe;
    logic               r_err;

    assign w_raw = {ps2_data, ps2_clk};

    // Each line: 2-flop synchronizer, then a level that only moves after
    // FILTER consecutive samples disagree with it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic                r_meta;
            logic                r_sync;
            logic                r_level;
            logic [c_FILT_W-1:0] r_cnt;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_meta  <= 1'b1;
                    r_sync  <= 1'b1;
                    r_level <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_meta <= w_raw[gi];
                    r_sync <= r_meta;
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_FILT_LAST) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_level;
        end
    endgenerate

    assign w_data = w_filt[1];
    assign w_fall = r_clk_prev & ~w_filt[0];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_clk_prev <= 1'b1;
        else          r_clk_prev <= w_filt[0];
    end

    assign w_par_ok = ^{r_shift, r_par};
    assign w_tmo    = (r_state != S_IDLE) && (r_tmo_cnt == c_TMO_LIM);

    // A falling edge wins over a simultaneous timeout expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_frame_bad = 1'b0;
        if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_data) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                default: begin
                    w_state_nxt = S_IDLE;
                    if (w_data && w_par_ok) w_byte_ok   = 1'b1;
                    else                    w_frame_bad = 1'b1;
                end
            endcase
        end else if (w_tmo) begin
            w_state_nxt = S_IDLE;
            w_frame_bad = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fall || r_state == S_IDLE) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_TMO_LIM) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    S_IDLE: r_bit_cnt <= 3'd0;
                    S_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_par <= w_data;
                    default: ;
                endcase
            end
        end
    end

    // Code decoder: prefixes set flags, a pending Pause swallow outranks all.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ext    <= 1'b0;
            r_rel    <= 1'b0;
            r_skip   <= 3'd0;
            r_key    <= 11'h000;
            r_strobe <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_err    <= w_frame_bad;
            if (w_frame_bad) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else begin
                    case (r_shift)
                        8'hE1: r_skip <= 3'd7;
                        8'hE0: r_ext  <= 1'b1;
                        8'hF0: r_rel  <= 1'b1;
                        8'h00, 8'hAA, 8'hEE, 8'hFA,
                        8'hFC, 8'hFE, 8'hFF: ;
                        default: begin
                            r_key    <= {~r_key[10], ~r_rel, r_ext, r_shift};
                            r_strobe <= 1'b1;
                            r_ext    <= 1'b0;
                            r_rel    <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign ps2_key    = r_key;
    assign key_strobe = r_strobe;
    assign frame_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_rx
// Brief    : Directed bench for ps2_key_rx with hand-computed key words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_rx;

    localparam int c_HALF    = 60;
    localparam int c_GAP     = 150;
    localparam int c_TIMEOUT = 24000;

    logic        clk_sys;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;

    int n_vec;
    int n_miss;
    int n_strobe;
    int n_err;
    int n_viol;
    int s0;
    int e0;
    logic r_prev_strobe;
    logic r_prev_err;

    ps2_key_rx #(.FILTER(8), .TIMEOUT(c_TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Event counters; pulses must be single-cycle and never coincide.
    initial begin
        n_strobe = 0; n_err = 0; n_viol = 0;
        r_prev_strobe = 1'b0; r_prev_err = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (key_strobe) n_strobe++;
            if (frame_err)  n_err++;
            if (key_strobe && frame_err) n_viol++;
            if ((key_strobe && r_prev_strobe) || (frame_err && r_prev_err)) n_viol++;
            r_prev_strobe = key_strobe;
            r_prev_err    = frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        idle(c_HALF);
        ps2_clk = 1'b0;
        idle(c_HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        idle(c_GAP);
    endtask

    task automatic mark;
        s0 = n_strobe;
        e0 = n_err;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        ps2_clk = 1'b1; ps2_data = 1'b1; reset_n = 1'b0;
        idle(10);
        check("reset_key",    32'(ps2_key),    32'h000);
        check("reset_strobe", 32'(key_strobe), 32'h0);
        check("reset_err",    32'(frame_err),  32'h0);
        reset_n = 1'b1;
        idle(50);

        // Make 1C from reset
        mark();
        send_byte(8'h1C, 1'b0);
        check("make_strobes", 32'(n_strobe - s0), 1);
        check("make_key",     32'(ps2_key),       32'h61C);

        // Extended break E0 F0 75
        mark();
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        check("ext_prefix_quiet", 32'(n_strobe - s0), 0);
        send_byte(8'h75, 1'b0);
        check("ext_strobes", 32'(n_strobe - s0), 1);
        check("ext_key",     32'(ps2_key),       32'h175);

        // Parity error then clean 29
        mark();
        send_byte(8'h1C, 1'b1);
        check("par_err",     32'(n_err - e0),    1);
        check("par_nostrb",  32'(n_strobe - s0), 0);
        check("par_keyhold", 32'(ps2_key),       32'h175);
        send_byte(8'h29, 1'b0);
        check("par_next_key", 32'(ps2_key), 32'h629);

        // Timeout after 4 bits, then 16
        mark();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(c_TIMEOUT + 10);
        check("tmo_err",    32'(n_err - e0),    1);
        check("tmo_nostrb", 32'(n_strobe - s0), 0);
        send_byte(8'h16, 1'b0);
        check("tmo_next_strb", 32'(n_strobe - s0), 1);
        check("tmo_next_key",  32'(ps2_key),       32'h216);

        // Pause sequence swallowed, then 5A
        mark();
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        check("pause_quiet", 32'(n_strobe - s0), 0);
        send_byte(8'h5A, 1'b0);
        check("pause_strb", 32'(n_strobe - s0), 1);
        check("pause_key",  32'(ps2_key),       32'h65A);
        check("pause_noerr", 32'(n_err - e0),   0);

        // Reset after 5 data bits of 1C
        mark();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset_n = 1'b0;
        ps2_data = 1'b1;
        idle(5);
        check("rst_key",    32'(ps2_key),    32'h000);
        check("rst_strobe", 32'(key_strobe), 32'h0);
        check("rst_err",    32'(frame_err),  32'h0);
        reset_n = 1'b1;
        idle(100);
        send_byte(8'h1C, 1'b0);
        check("rst_next_key",  32'(ps2_key),       32'h61C);
        check("rst_next_strb", 32'(n_strobe - s0), 1);
        check("rst_no_err",    32'(n_err - e0),    0);

        check("pulse_rules", 32'(n_viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
